// File: rtl/debug_unit_fsm.sv
// Debugger control FSM between the UART byte interfaces and the pipelined processor.
// Define FSM_CYCLE_COUNT_EN to append a 4-byte stepped-cycle counter to every snapshot dump.
module debug_unit_fsm #(
   parameter int          DATA_BITS = 2560,
   parameter int          ADDR_BITS = 8,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           i_rx_data,
   input  logic [DATA_BITS-1:0] i_data_from_pipe,
   input  logic                 is_rx_done,
   input  logic                 is_tx_done,
   input  logic                 is_stop_pipe,
   output logic                 o_step,
   output logic [ADDR_BITS-1:0] o_address,
   output logic [31:0]          o_instruction,
   output logic [7:0]           o_tx_data,
   output logic                 os_tx_start,
   output logic                 os_MemWrite
);

   localparam int NBYTES = DATA_BITS / 8;
`ifdef FSM_CYCLE_COUNT_EN
   localparam int TOTAL = NBYTES + 4;
`else
   localparam int TOTAL = NBYTES;
`endif
   localparam int                  IDX_BITS = $clog2(TOTAL + 1);
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(TOTAL - 1);

   localparam logic [7:0] CMD_LOAD  = 8'h01;
   localparam logic [7:0] CMD_RUN   = 8'h02;
   localparam logic [7:0] CMD_STEP  = 8'h03;
   localparam logic [7:0] CMD_PULSE = 8'h04;
   localparam logic [7:0] CMD_EXIT  = 8'h05;

   typedef enum logic [2:0] {
      IDLE, LOAD, RUN, STEP_WAIT, STEP_PULSE, SEND, SEND_WAIT
   } state_t;

   state_t              state, state_nxt;
   logic [1:0]          byte_cnt;
   logic [IDX_BITS-1:0] idx;
   logic                from_step;
   logic                stop_seen;
   logic                tx_ack;
   logic [7:0]          tx_byte;

   // A done coinciding with our own start pulse belongs to the previous byte, not this one.
   assign tx_ack = is_tx_done && !os_tx_start;

`ifdef FSM_CYCLE_COUNT_EN
   logic [31:0] cycle_cnt;
   logic [1:0]  cnt_idx;

   always_ff @(posedge clk) begin
      if (rst)
         cycle_cnt <= '0;
      else if (state == IDLE && is_rx_done && (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP))
         cycle_cnt <= '0;
      else if (o_step && cycle_cnt != '1)
         cycle_cnt <= cycle_cnt + 32'd1;
   end

   always_comb begin
      cnt_idx = 2'(idx - IDX_BITS'(NBYTES));
      tx_byte = i_data_from_pipe[{idx, 3'b000} +: 8];
      if (idx >= IDX_BITS'(NBYTES))
         tx_byte = cycle_cnt[{cnt_idx, 3'b000} +: 8];
   end
`else
   always_comb begin
      tx_byte = i_data_from_pipe[{idx, 3'b000} +: 8];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      o_step    = 1'b0;
      case (state)
         IDLE:
            if (is_rx_done) begin
               case (i_rx_data)
                  CMD_LOAD: state_nxt = LOAD;
                  CMD_RUN:  state_nxt = RUN;
                  CMD_STEP: state_nxt = STEP_WAIT;
                  default:  state_nxt = IDLE;
               endcase
            end
         LOAD:
            if (os_MemWrite && o_instruction == HALT_WORD)
               state_nxt = IDLE;
         RUN: begin
            o_step = 1'b1;
            if (is_stop_pipe)
               state_nxt = SEND;
         end
         STEP_WAIT:
            if (is_rx_done) begin
               if (i_rx_data == CMD_PULSE)
                  state_nxt = STEP_PULSE;
               else if (i_rx_data == CMD_EXIT)
                  state_nxt = IDLE;
            end
         STEP_PULSE: begin
            o_step    = 1'b1;
            state_nxt = SEND;
         end
         SEND:
            state_nxt = SEND_WAIT;
         SEND_WAIT:
            if (tx_ack) begin
               if (idx == LAST_IDX)
                  state_nxt = (from_step && !stop_seen && !is_stop_pipe) ? STEP_WAIT : IDLE;
               else
                  state_nxt = SEND;
            end
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_address     <= '0;
         o_instruction <= '0;
         o_tx_data     <= '0;
         os_tx_start   <= 1'b0;
         os_MemWrite   <= 1'b0;
         byte_cnt      <= '0;
         idx           <= '0;
         from_step     <= 1'b0;
         stop_seen     <= 1'b0;
      end else begin
         os_tx_start <= 1'b0;
         os_MemWrite <= 1'b0;
         case (state)
            IDLE:
               if (is_rx_done && i_rx_data == CMD_LOAD) begin
                  o_address <= '0;
                  byte_cnt  <= '0;
               end
            LOAD: begin
               if (is_rx_done) begin
                  o_instruction <= {o_instruction[23:0], i_rx_data};
                  byte_cnt      <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3)
                     os_MemWrite <= 1'b1;
               end
               if (os_MemWrite)
                  o_address <= o_address + 1'b1;
            end
            RUN: begin
               from_step <= 1'b0;
               idx       <= '0;
            end
            STEP_WAIT:
               if (is_rx_done && i_rx_data == CMD_PULSE) begin
                  from_step <= 1'b1;
                  stop_seen <= 1'b0;
               end
            STEP_PULSE: begin
               idx <= '0;
               if (is_stop_pipe)
                  stop_seen <= 1'b1;
            end
            SEND: begin
               os_tx_start <= 1'b1;
               o_tx_data   <= tx_byte;
               if (is_stop_pipe)
                  stop_seen <= 1'b1;
            end
            SEND_WAIT: begin
               if (is_stop_pipe)
                  stop_seen <= 1'b1;
               if (tx_ack)
                  idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_unit_fsm.sv
// Scoreboard bench for debug_unit_fsm: expected memory writes and tx bytes are queued at
// stimulus time from the command protocol and popped by monitors when the DUT emits them.
module tb_debug_unit_fsm;

   localparam int DATA_BITS = 2560;
   localparam int NB        = DATA_BITS / 8;
`ifdef FSM_CYCLE_COUNT_EN
   localparam int TOTAL = NB + 4;
`else
   localparam int TOTAL = NB;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [7:0]           i_rx_data = '0;
   logic [DATA_BITS-1:0] i_data_from_pipe = '0;
   logic                 is_rx_done = 1'b0;
   logic                 is_tx_done = 1'b0;
   logic                 is_stop_pipe = 1'b0;
   logic                 o_step;
   logic [7:0]           o_address;
   logic [31:0]          o_instruction;
   logic [7:0]           o_tx_data;
   logic                 os_tx_start;
   logic                 os_MemWrite;

   debug_unit_fsm #(.DATA_BITS(DATA_BITS), .ADDR_BITS(8), .HALT_WORD(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_data_from_pipe(i_data_from_pipe),
      .is_rx_done(is_rx_done), .is_tx_done(is_tx_done), .is_stop_pipe(is_stop_pipe),
      .o_step(o_step), .o_address(o_address), .o_instruction(o_instruction),
      .o_tx_data(o_tx_data), .os_tx_start(os_tx_start), .os_MemWrite(os_MemWrite)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int tx_count = 0, wr_count = 0, step_cycles = 0;
   bit tx_busy = 1'b0;
   logic [7:0]  tx_q[$];
   logic [39:0] wr_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard whenever the DUT presents a write or a tx byte.
   initial forever begin
      @(posedge clk); #1;
      if (!rst) begin
         if (os_tx_start) begin
            tx_count++;
            if (tx_busy) check("tx_handshake", 1, 0);
            tx_busy = 1'b1;
            if (tx_q.size() == 0) check("tx_unexpected", {56'd0, o_tx_data}, 64'hDEAD);
            else check("tx_byte", {56'd0, o_tx_data}, {56'd0, tx_q.pop_front()});
         end
         if (os_MemWrite) begin
            wr_count++;
            if (wr_q.size() == 0) check("wr_unexpected", {o_address, o_instruction}, 64'hDEAD);
            else check("mem_write", {o_address, o_instruction}, {24'd0, wr_q.pop_front()});
         end
         if (o_step) step_cycles++;
      end
   end

   // UART transmitter model: acknowledges each start after a random latency.
   initial forever begin
      @(posedge clk); #1;
      if (os_tx_start && !rst) begin
         repeat ($urandom_range(2, 5)) @(negedge clk);
         is_tx_done = 1'b1;
         tx_busy    = 1'b0;
         @(negedge clk);
         is_tx_done = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      i_rx_data  = b;
      is_rx_done = 1'b1;
      @(negedge clk);
      is_rx_done = 1'b0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic rand_data(output logic [DATA_BITS-1:0] d);
      for (int i = 0; i < DATA_BITS / 32; i++) d[i*32 +: 32] = $urandom;
   endtask

   // Snapshot bytes LSB first, then (when enabled) the cycle count LSB first.
   task automatic push_dump(input logic [DATA_BITS-1:0] d, input logic [31:0] cnt);
      for (int k = 0; k < TOTAL; k++)
         tx_q.push_back((k < NB) ? d[k*8 +: 8] : cnt[(k-NB)*8 +: 8]);
   endtask

   task automatic wait_dump(input string name);
      int n = 0;
      while (tx_q.size() != 0 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8000) begin
         check({name, "_timeout"}, tx_q.size(), 0);
         tx_q.delete();
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic load_words(input logic [31:0] words[$]);
      send_byte(8'h01);
      for (int w = 0; w < words.size(); w++) begin
         wr_q.push_back({8'(w), words[w]});
         for (int b = 3; b >= 0; b--) begin
            gap();
            send_byte(words[w][b*8 +: 8]);
         end
      end
      repeat (6) @(negedge clk);
      check("load_all_written", wr_q.size(), 0);
   endtask

   task automatic run_dump(input logic [DATA_BITS-1:0] d, input int n);
      int t0, s0;
      i_data_from_pipe = d;
      push_dump(d, 32'(n + 1));
      t0 = tx_count;
      s0 = step_cycles;
      send_byte(8'h02);
      repeat (n) @(negedge clk);
      check("run_step_high", o_step, 1);
      is_stop_pipe = 1'b1;
      @(negedge clk);
      is_stop_pipe = 1'b0;
      check("run_step_low", o_step, 0);
      wait_dump("run");
      check("run_tx_count", tx_count - t0, TOTAL);
      check("run_step_cycles", step_cycles - s0, n + 1);
   endtask

   task automatic step_dump(input logic [DATA_BITS-1:0] d, input int cnt, input bit with_stop);
      int t0, s0;
      i_data_from_pipe = d;
      push_dump(d, 32'(cnt));
      t0 = tx_count;
      s0 = step_cycles;
      @(negedge clk);
      i_rx_data  = 8'h04;
      is_rx_done = 1'b1;
      @(negedge clk);
      is_rx_done   = 1'b0;
      is_stop_pipe = with_stop;
      @(negedge clk);
      is_stop_pipe = 1'b0;
      wait_dump("step");
      check("step_tx_count", tx_count - t0, TOTAL);
      check("step_single_cycle", step_cycles - s0, 1);
   endtask

   task automatic expect_quiet(input string name, input logic [7:0] b);
      int t0, w0, s0;
      t0 = tx_count; w0 = wr_count; s0 = step_cycles;
      send_byte(b);
      repeat (20) @(negedge clk);
      check({name, "_tx"}, tx_count - t0, 0);
      check({name, "_wr"}, wr_count - w0, 0);
      check({name, "_step"}, step_cycles - s0, 0);
   endtask

   initial begin
      logic [DATA_BITS-1:0] d;
      logic [31:0]          words[$];
      int                   t0, s0, n;

      repeat (5) @(negedge clk);
      check("rst_step", o_step, 0);
      check("rst_memwrite", os_MemWrite, 0);
      check("rst_tx_start", os_tx_start, 0);
      check("rst_address", o_address, 0);
      check("rst_instruction", o_instruction, 0);
      check("rst_tx_data", o_tx_data, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      words = '{32'hFF00_FF00, 32'hFFFF_FFFF};
      load_words(words);
      d = '0;
      d[3:0] = 4'hF;
      run_dump(d, 3);

      words = {};
      for (int i = 0; i < 4; i++) words.push_back($urandom | 32'h1 ^ 32'h1 ^ 32'h0000_0100 ^ 32'(i));
      words.push_back(32'hFFFF_FFFF);
      load_words(words);

      expect_quiet("unknown_cmd", 8'h7A);

      send_byte(8'h03);
      s0 = step_cycles;
      repeat (5) @(negedge clk);
      check("step_wait_stalled", step_cycles - s0, 0);
      rand_data(d);
      step_dump(d, 1, 1'b0);
      rand_data(d);
      step_dump(d, 2, 1'b0);
      send_byte(8'h05);
      expect_quiet("step_exit", 8'h04);

      send_byte(8'h03);
      rand_data(d);
      step_dump(d, 1, 1'b1);
      expect_quiet("stop_latched", 8'h04);

      rand_data(d);
      i_data_from_pipe = d;
      push_dump(d, 32'd4);
      t0 = tx_count;
      send_byte(8'h02);
      repeat (3) @(negedge clk);
      is_stop_pipe = 1'b1;
      @(negedge clk);
      is_stop_pipe = 1'b0;
      n = 0;
      while (tx_count - t0 < 40 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("mid_dump_progress", (tx_count - t0 >= 40), 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tx_q.delete();
      rst = 1'b0;
      t0 = tx_count;
      repeat (20) @(negedge clk);
      tx_busy = 1'b0;
      check("reset_quiet", tx_count - t0, 0);
      check("reset_step_low", o_step, 0);
      rand_data(d);
      run_dump(d, 5);

      for (int r = 0; r < 2; r++) begin
         rand_data(d);
         run_dump(d, $urandom_range(1, 20));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      check("global_timeout", 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/debug_unit_fsm.md
Name: debug_unit_fsm

Overview:
Control FSM of the pipeline debugger unit, sitting between the UART (rx/tx byte interfaces) and the pipelined processor. It decodes single-byte host commands to:
- load a program into instruction memory;
- run the pipeline continuously or one step at a time;
- stream the 2560-bit pipeline state snapshot back to the host byte by byte.

Parameters:
DATA_BITS, 2560, width of pipeline snapshot (multiple of 8; NBYTES = DATA_BITS/8 = 320)
ADDR_BITS, 8, instruction memory word-address width
HALT_WORD, 32'hFFFFFFFF, instruction value that terminates program load

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
i_rx_data  input  8  byte from UART receiver, valid when is_rx_done=1
i_data_from_pipe  input  DATA_BITS  pipeline state snapshot (PC, registers, latches, memory)
is_rx_done  input  1  one-cycle strobe: new rx byte available
is_tx_done  input  1  one-cycle strobe: UART finished sending current byte
is_stop_pipe  input  1  pipeline executed HALT / halted
o_step  output  1  pipeline enable (advance one cycle when high)
o_address  output  ADDR_BITS  instruction memory write word address
o_instruction  output  32  instruction word to write
o_tx_data  output  8  byte to transmit
os_tx_start  output  1  one-cycle strobe: start transmitting o_tx_data
os_MemWrite  output  1  one-cycle instruction memory write enable

Behaviour:
- One clock (clk); reset synchronous, active-high. Reset from any state goes to IDLE. All outputs clear to 0. Byte/word counters clear.
- States: IDLE, LOAD, RUN, STEP_WAIT, STEP_PULSE, SEND, SEND_WAIT.
- IDLE: on is_rx_done, decode i_rx_data:
  - 0x01 -> LOAD; o_address cleared to 0.
  - 0x02 -> RUN.
  - 0x03 -> STEP_WAIT.
  - Any other byte is ignored.
- LOAD:
  - Collect 4 rx bytes MSB first into o_instruction (shift left 8, insert new byte in [7:0]).
  - The cycle after the 4th byte: os_MemWrite=1 for exactly one cycle with o_address/o_instruction stable.
  - o_address increments by 1 the cycle after the write; wraps 255->0.
  - If the written word == HALT_WORD, return to IDLE after the write; the HALT word is itself written.
- RUN:
  - o_step=1 from the cycle after the command byte.
  - On is_stop_pipe, o_step=0 the next cycle and go to SEND.
- STEP_WAIT:
  - o_step=0. On rx byte 0x04 -> STEP_PULSE. On 0x05 -> IDLE. Other bytes ignored.
- STEP_PULSE:
  - o_step=1 for exactly one cycle, then SEND.
- SEND / SEND_WAIT:
  - Byte index k runs 0..NBYTES-1. o_tx_data = i_data_from_pipe[8k+7:8k], so byte 0 = bits[7:0].
  - os_tx_start pulses one cycle per byte, then the FSM waits in SEND_WAIT for is_tx_done before the next byte.
  - After the last byte's is_tx_done:
    - if entered from STEP_PULSE and is_stop_pipe has not been seen since the step command, go to STEP_WAIT;
    - otherwise go to IDLE.
  - The snapshot is sampled live; the pipeline is stalled (o_step=0) during send.
- is_rx_done outside IDLE/LOAD/STEP_WAIT is ignored. is_tx_done outside SEND_WAIT is ignored.
- is_stop_pipe coincident with a step pulse is latched and honoured at the end of that dump.
- o_instruction holds its last value outside LOAD.

Optional Feature:
Macro FSM_CYCLE_COUNT_EN.
- With it defined:
  - A 32-bit counter increments every cycle o_step=1 and clears on the 0x02/0x03 command.
  - After the NBYTES snapshot bytes, 4 extra bytes of the counter are sent LSB first, using the same start/done handshake.
  - Counter saturates at 0xFFFFFFFF.
- Without it: exactly NBYTES bytes are sent and no counter exists.

Test Plan:
- Reset: hold rst=1 for 5 cycles -> o_step, os_MemWrite, os_tx_start, o_address, o_instruction, o_tx_data all 0.
- Load: bytes 0x01, FF,00,FF,00, FF,FF,FF,FF ->
  - os_MemWrite pulse at address 0 with 0xFF00FF00;
  - pulse at address 1 with 0xFFFFFFFF;
  - FSM back in IDLE, and a further 0x02 starts RUN.
- Run/dump: i_data_from_pipe[3:0]=4'hF, rest 0; byte 0x02 -> o_step=1; pulse is_stop_pipe -> o_step=0.
  - First os_tx_start has o_tx_data=0x0F; next bytes 0x00.
  - Exactly 320 tx starts (324 with FSM_CYCLE_COUNT_EN), each only after is_tx_done. Then IDLE.
- Step: 0x03 then 0x04 -> single-cycle o_step, then 320-byte dump, then STEP_WAIT. 0x05 -> IDLE with no o_step.
- Robustness:
  - Unknown command 0x7A in IDLE -> no output activity.
  - rst asserted mid-dump -> os_tx_start stops and next command 0x02 restarts from byte 0.
